fifo_flow_ctrl: RTL and testbench
=================================

Name: fifo_flow_ctrl

Overview:
- Valid/ready front-end and back-end controller for the 256x9 pointer-based FIFO storage block.
- Drives the storage control pins (wren, WrInc, rden, RdInc, RdPtrClr, WrPtrClr) and tracks occupancy, since the storage has no full/empty logic.
- Absorbs the storage's one-cycle registered read latency with a 2-entry output buffer, giving a streaming 1-word/cycle valid/ready interface.

Parameters:
DW, 9, data width
AW, 8, storage address width
DEPTH, 256, storage entries (2**AW)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all contents, one cycle
in_valid  in  1  producer has a word
in_ready  out  1  controller accepts the word this cycle
in_data  in  DW  producer word
out_valid  out  1  out_data holds a word
out_ready  in  1  consumer takes the word this cycle
out_data  out  DW  head word
st_wren  out  1  to storage wren
st_wrinc  out  1  to storage WrInc
st_din  out  DW  to storage DataIn (= in_data)
st_rden  out  1  to storage rden
st_rdinc  out  1  to storage RdInc
st_rdptrclr  out  1  to storage RdPtrClr
st_wrptrclr  out  1  to storage WrPtrClr
st_dout  in  DW  from storage DataOut (valid only the cycle after st_rden; 9'hF otherwise)
count  out  AW+2  total words held (storage + in-flight + output buffer), 0..DEPTH+2
full  out  1  storage holds DEPTH words
empty  out  1  count == 0

Behaviour:
- Reset (rst=1): at the next edge mem_cnt=0, rd_pend=0, out_cnt=0, out_valid=0, out_data=0, count=0, full=0, empty=1.
  - During rst: in_ready=0, st_wren=st_rden=0, st_rdptrclr=st_wrptrclr=1 (combinational from rst|flush).
- Flush: same effect as rst on all state and outputs, applied in the cycle flush=1. In-flight read data is discarded; a push offered that cycle is not accepted (in_ready=0).
- Push:
  - in_ready = !full & !rst & !flush; push = in_valid & in_ready.
  - st_wren = st_wrinc = push; st_din = in_data.
- Read issue:
  - occ = out_cnt + rd_pend; pop = out_valid & out_ready.
  - issue = (mem_cnt != 0) & (occ - pop < 2) & !rst & !flush.
  - st_rden = st_rdinc = issue; rd_pend <= issue.
  - mem_cnt uses the registered value, so a word written at edge N is readable from cycle N+1. No same-address read/write in one cycle.
- Capture: when rd_pend=1, st_dout is written into the 2-entry output buffer (FIFO order) at the end of that cycle.
  - st_dout is never sampled when rd_pend=0 (storage drives 9'hF).
- Output: out_valid = (out_cnt != 0); out_data = oldest buffer entry, registered. Pop and capture in the same cycle are both honoured; ordering is preserved.
- Counters:
  - mem_cnt <= mem_cnt + push - issue (range 0..DEPTH).
  - full = (mem_cnt == DEPTH); count = mem_cnt + rd_pend + out_cnt.
  - All registered; count and full reflect state after the edge.
- Latency: word accepted at edge N appears with out_valid=1 at cycle N+3 when the FIFO is empty (issue N+1, st_dout N+2, captured at edge N+2 end).
- Throughput: one push and one pop per cycle sustained. Capacity is DEPTH+2 words before in_ready falls when out_ready=0.
- Wrap: storage pointers wrap modulo 256 on their own; mem_cnt alone decides full/empty, so no pointer comparison is needed.
- Simultaneous push and issue at mem_cnt==DEPTH: issue frees a slot at the next edge. in_ready stays 0 in the current cycle (no combinational path from issue to in_ready).

Decomposition:
- Package fifo_pkg: DW, AW, DEPTH, count width (AW+2).
- One sub-module, out_skid2: 2-entry output buffer with write (capture), valid/ready read, and out_cnt. The controller top holds mem_cnt, rd_pend, issue logic and storage pins.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> in_ready=0, st_rdptrclr=st_wrptrclr=1, out_valid=0, count=0, empty=1; after release, in_ready=1.
- Single word: push 9'h1A5 at edge N, out_ready=1 -> st_rden in cycle N+1, out_valid=1 with out_data=9'h1A5 in cycle N+3, then empty=1.
- Fill: out_ready=0, push 0..257 -> all 258 accepted, in_ready=0 and full=1 after the 258th, count=258. Then drain with out_ready=1 -> outputs 0..257 in order.
- Streaming wrap: in_valid=out_ready=1 continuously for 600 words (incrementing data) -> after initial latency, one pop per cycle, data in order across both pointer wraps, count steady at 3.
- Flush mid-stream: 100 words held with a read pending, pulse flush -> next cycle count=0, out_valid=0, both ptr clears seen. Next push 9'h055 emerges first.
- Backpressure: random out_ready (50%) and in_valid (70%) for 2000 cycles -> scoreboard matches exactly, no push accepted when full, st_rden never asserted when mem_cnt=0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg: shared sizing constants for the FIFO flow controller     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fifo_pkg;
  localparam int c_dw    = 9;
  localparam int c_aw    = 8;
  localparam int c_depth = 1 << c_aw;
  localparam int c_cw    = c_aw + 2;
endpackage
`default_nettype wire

// File: rtl/out_skid2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | out_skid2: 2-entry output buffer, capture write + valid/ready read |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module out_skid2
  import fifo_pkg::*;
#(
  parameter int DW = c_dw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_ready,
  output logic          o_valid,
  output logic          o_pop,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_cnt
);

  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic [1:0]    r_cnt;

  assign o_valid = (r_cnt != 2'd0);
  assign o_pop   = o_valid & i_ready;
  assign o_data  = r_d0;
  assign o_cnt   = r_cnt;

  // The issuer never lets a write arrive while both entries are held
  // unless the head is popped in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      case ({o_pop, i_wr})
        2'b01: begin
          if (r_cnt == 2'd0) r_d0 <= i_wdata;
          else               r_d1 <= i_wdata;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b10: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_d0 <= r_d1;
            r_d1 <= i_wdata;
          end else begin
            r_d0 <= i_wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_flow_ctrl: valid/ready controller for 256x9 pointer storage   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter int DW    = c_dw,
  parameter int AW    = c_aw,
  parameter int DEPTH = c_depth
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          st_wren,
  output logic          st_wrinc,
  output logic [DW-1:0] st_din,
  output logic          st_rden,
  output logic          st_rdinc,
  output logic          st_rdptrclr,
  output logic          st_wrptrclr,
  input  logic [DW-1:0] st_dout,
  output logic [AW+1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int            c_cnt_w    = AW + 2;
  localparam logic [AW:0]   c_full_cnt = (AW + 1)'(DEPTH);

  logic          w_clr;
  logic          w_push;
  logic          w_issue;
  logic          w_pop;
  logic [1:0]    w_out_cnt;
  logic [2:0]    w_occ_left;
  logic [AW:0]   r_mem_cnt;
  logic          r_rd_pend;

  assign w_clr       = rst | flush;
  assign st_rdptrclr = w_clr;
  assign st_wrptrclr = w_clr;

  assign full     = (r_mem_cnt == c_full_cnt);
  assign in_ready = !full & !w_clr;
  assign w_push   = in_valid & in_ready;
  assign st_wren  = w_push;
  assign st_wrinc = w_push;
  assign st_din   = in_data;

  // Output-side slots still claimed after this cycle's pop; a new read may
  // only be launched if the buffer can absorb it when the data lands.
  assign w_occ_left = {1'b0, w_out_cnt} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_issue    = (r_mem_cnt != '0) && (w_occ_left < 3'd2) && !w_clr;
  assign st_rden    = w_issue;
  assign st_rdinc   = w_issue;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem_cnt <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_mem_cnt <= r_mem_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_issue};
      r_rd_pend <= w_issue;
    end
  end

  out_skid2 #(
    .DW(DW)
  ) u_skid (
    .clk     (clk),
    .rst     (w_clr),
    .i_wr    (r_rd_pend),
    .i_wdata (st_dout),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_pop   (w_pop),
    .o_data  (out_data),
    .o_cnt   (w_out_cnt)
  );

  assign count = c_cnt_w'(r_mem_cnt) + c_cnt_w'(r_rd_pend) + c_cnt_w'(w_out_cnt);
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: tb/tb_fifo_flow_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_flow_ctrl: scoreboard bench with a 256x9 storage model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fifo_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic       st_wren, st_wrinc, st_rden, st_rdinc, st_rdptrclr, st_wrptrclr;
  logic [8:0] st_din;
  logic [8:0] st_dout = 9'h00F;
  logic [9:0] count;
  logic       full, empty;

  int         total = 0;
  int         bad = 0;
  int         exp_count = 0;
  int         st_mcnt = 0;
  bit         mon_en = 1'b0;
  logic [8:0] q[$];

  logic [8:0] mem [0:255];
  logic [7:0] wrptr = '0;
  logic [7:0] rdptr = '0;

  always #5 clk = ~clk;

  fifo_flow_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .st_wren(st_wren), .st_wrinc(st_wrinc), .st_din(st_din),
    .st_rden(st_rden), .st_rdinc(st_rdinc),
    .st_rdptrclr(st_rdptrclr), .st_wrptrclr(st_wrptrclr),
    .st_dout(st_dout), .count(count), .full(full), .empty(empty)
  );

  // Storage model: pointer-based RAM with registered read, 9'hF when idle.
  always @(posedge clk) begin
    if (st_wren) mem[wrptr] <= st_din;
    wrptr   <= st_wrptrclr ? 8'd0 : (st_wrinc ? wrptr + 8'd1 : wrptr);
    rdptr   <= st_rdptrclr ? 8'd0 : (st_rdinc ? rdptr + 8'd1 : rdptr);
    st_dout <= st_rden ? mem[rdptr] : 9'h00F;
    st_mcnt <= (st_wrptrclr || st_rdptrclr) ? 0
             : st_mcnt + int'(st_wren) - int'(st_rden);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and tracks occupancy.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(exp_count));
      chk("empty", 32'(empty), 32'(exp_count == 0));
      chk("wren", 32'(st_wren), 32'(in_valid && in_ready));
      chk("ptrclr", {30'd0, st_rdptrclr, st_wrptrclr}, {30'd0, {2{rst | flush}}});
      chk("rden_on_empty_mem", 32'(st_rden && st_mcnt == 0), 32'd0);
      chk("wren_on_full_mem", 32'(st_wren && st_mcnt == 256), 32'd0);
      chk("ready_at_capacity", (exp_count == 258) ? 32'(in_ready) : 32'd0, 32'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h want none at %0t", out_data, $time);
        end else begin
          chk("out_data", 32'(out_data), 32'(q.pop_front()));
        end
      end
      if (rst || flush) begin
        exp_count = 0;
        q.delete();
      end else begin
        exp_count = exp_count + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [8:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(d);
        break;
      end
      n++;
      if (n > 1000) begin
        chk("push_timeout", 32'd1, 32'd0);
        break;
      end
      step();
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (q.size() > 0 && n < 800) begin
      step();
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    repeat (2) step();
    chk("drained_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles with a word offered
    in_valid = 1'b1;
    in_data  = 9'h0AA;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_clr", {30'd0, st_rdptrclr, st_wrptrclr}, 32'd3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_wren", 32'(st_wren), 32'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // Single word latency
    out_ready = 1'b1;
    push_word(9'h1A5);
    @(negedge clk);
    chk("single_rden_n1", 32'(st_rden), 32'd1);
    chk("single_ov_n1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_ov_n2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_ov_n3", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h1A5);
    @(negedge clk);
    chk("single_empty", 32'(empty), 32'd1);
    step();

    // Streaming across both pointer wraps
    out_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      push_word(9'(i));
      if (i >= 4 && (i % 50) == 0) chk("stream_count", 32'(count), 32'd3);
    end
    drain();

    // Fill to capacity with no consumer
    out_ready = 1'b0;
    for (int j = 0; j < 258; j++) push_word(9'(j));
    @(negedge clk);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd258);
    step();
    in_valid = 1'b1;
    in_data  = 9'h1FF;
    repeat (3) step();
    in_valid = 1'b0;
    drain();

    // Flush with a read in flight
    out_ready = 1'b0;
    for (int k = 0; k < 100; k++) push_word(9'h100 + 9'(k));
    repeat (4) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pre_flush_count", 32'(count), 32'd99);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_clr", {30'd0, st_rdptrclr, st_wrptrclr}, 32'd3);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    push_word(9'h055);
    drain();

    // Random backpressure
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 9'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
